// File: rtl/cache_fill_arbiter.sv
// cache_fill_arbiter: shares main memory between I/D caches, running block fills and D-cache write-through stores.
// Memory is pipelined: reads issue back-to-back while returns are written into the owned cache in order.
module cache_fill_arbiter #(
   parameter int MEM_LATENCY = 4,
   parameter int WORDS       = 8
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        ic_miss_i,
   input  logic [15:0] ic_addr_i,
   input  logic        dc_miss_i,
   input  logic [15:0] dc_addr_i,
   input  logic        dc_store_i,
   input  logic [15:0] dc_store_data_i,
   output logic        mem_en_o,
   output logic        mem_wr_o,
   output logic [15:0] mem_addr_o,
   output logic [15:0] mem_wdata_o,
   input  logic [15:0] mem_rdata_i,
   input  logic        mem_data_valid_i,
   output logic        ic_busy_o,
   output logic        dc_busy_o,
   output logic        cache_en_o,
   output logic [1:0]  cache_op_o,
   output logic [15:0] cache_addr_o,
   output logic [15:0] cache_data_o,
   output logic        ic_fill_done_o,
   output logic        dc_fill_done_o,
   output logic        dc_store_done_o
);
   typedef enum logic [2:0] {IDLE, FILL, TAG, DONE, WRITE} state_t;
   localparam logic [3:0] W4   = 4'(WORDS);
   localparam logic [3:0] LAST = 4'(WORDS - 1);
   if (WORDS < 1 || WORDS > 15 || MEM_LATENCY < 1) begin : g_bad_params
      $error("cache_fill_arbiter: unsupported parameters");
   end
   state_t      state_q;
   logic [3:0]  i_q, r_q;
   logic [15:0] base_q;
   logic        owner_q, last_q;
   logic        ic_busy_q, dc_busy_q, ic_done_q, dc_done_q, st_done_q;
   logic        grant_dc, issue, fill_wr, tag, wr;
   logic [15:0] miss_addr;
   // owner/last_served encoding: 1 = D-cache, 0 = I-cache
   assign grant_dc  = dc_miss_i & (~ic_miss_i | ~last_q);
   assign miss_addr = grant_dc ? dc_addr_i : ic_addr_i;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         i_q       <= '0;
         r_q       <= '0;
         base_q    <= '0;
         owner_q   <= 1'b0;
         last_q    <= 1'b0;
         ic_busy_q <= 1'b0;
         dc_busy_q <= 1'b0;
         ic_done_q <= 1'b0;
         dc_done_q <= 1'b0;
         st_done_q <= 1'b0;
      end else begin
         ic_done_q <= 1'b0;
         dc_done_q <= 1'b0;
         st_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               i_q <= '0;
               r_q <= '0;
               if (ic_miss_i | dc_miss_i) begin
                  state_q   <= FILL;
                  base_q    <= miss_addr & 16'hFFF0;
                  owner_q   <= grant_dc;
                  last_q    <= grant_dc;
                  ic_busy_q <= ~grant_dc;
                  dc_busy_q <= grant_dc;
               end else if (dc_store_i) begin
                  state_q   <= WRITE;
                  st_done_q <= 1'b1;
               end
            end
            FILL: begin
               if (i_q < W4) i_q <= i_q + 4'd1;
               if (mem_data_valid_i) begin
                  r_q <= r_q + 4'd1;
                  if (r_q == LAST) state_q <= TAG;
               end
            end
            TAG: begin
               state_q   <= DONE;
               ic_busy_q <= 1'b0;
               dc_busy_q <= 1'b0;
               ic_done_q <= ~owner_q;
               dc_done_q <= owner_q;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign issue   = (state_q == FILL) && (i_q < W4);
   assign fill_wr = (state_q == FILL) && mem_data_valid_i;
   assign tag     = (state_q == TAG);
   assign wr      = (state_q == WRITE);
   assign mem_en_o        = issue | wr;
   assign mem_wr_o        = wr;
   assign mem_addr_o      = wr ? dc_addr_i : issue ? base_q + {11'd0, i_q, 1'b0} : '0;
   assign mem_wdata_o     = wr ? dc_store_data_i : '0;
   assign cache_en_o      = fill_wr | tag;
   assign cache_op_o      = fill_wr ? 2'b01 : tag ? 2'b10 : 2'b00;
   assign cache_addr_o    = fill_wr ? base_q + {11'd0, r_q, 1'b0} : tag ? base_q : '0;
   assign cache_data_o    = mem_rdata_i;
   assign ic_busy_o       = ic_busy_q;
   assign dc_busy_o       = dc_busy_q;
   assign ic_fill_done_o  = ic_done_q;
   assign dc_fill_done_o  = dc_done_q;
   assign dc_store_done_o = st_done_q;
endmodule

// File: tb/tb_cache_fill_arbiter.sv
// tb_cache_fill_arbiter: directed checks of fills, arbitration, stores and reset against a 4-cycle memory.
module tb_cache_fill_arbiter;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        ic_miss = 1'b0, dc_miss = 1'b0, dc_store = 1'b0, spur = 1'b0;
   logic [15:0] ic_addr = '0, dc_addr = '0, dc_store_data = '0;
   logic        mem_en, mem_wr, mem_data_valid;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        ic_busy, dc_busy, cache_en, ic_fill_done, dc_fill_done, dc_store_done;
   logic [1:0]  cache_op;
   logic [15:0] cache_addr, cache_data;
   logic [3:0]  vld;
   logic [15:0] ap [4];
   int          n_tests = 0, n_fail = 0;

   cache_fill_arbiter dut (
      .clk_i(clk), .rst_ni(rst_n),
      .ic_miss_i(ic_miss), .ic_addr_i(ic_addr),
      .dc_miss_i(dc_miss), .dc_addr_i(dc_addr),
      .dc_store_i(dc_store), .dc_store_data_i(dc_store_data),
      .mem_en_o(mem_en), .mem_wr_o(mem_wr), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
      .mem_rdata_i(mem_rdata), .mem_data_valid_i(mem_data_valid),
      .ic_busy_o(ic_busy), .dc_busy_o(dc_busy),
      .cache_en_o(cache_en), .cache_op_o(cache_op), .cache_addr_o(cache_addr), .cache_data_o(cache_data),
      .ic_fill_done_o(ic_fill_done), .dc_fill_done_o(dc_fill_done), .dc_store_done_o(dc_store_done)
   );

   always #5 clk = ~clk;

   // memory: a read issued in cycle n returns in cycle n+4 with data 0xA000 + word index
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld <= '0;
         for (int k = 0; k < 4; k++) ap[k] <= '0;
      end else begin
         vld   <= {vld[2:0], mem_en & ~mem_wr};
         ap[0] <= mem_addr;
         for (int k = 1; k < 4; k++) ap[k] <= ap[k-1];
      end
   end
   assign mem_data_valid = vld[3] | spur;
   assign mem_rdata      = 16'hA000 + {13'd0, ap[3][3:1]};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [41:0] obs();
      return {mem_en, mem_wr, mem_addr, cache_en, cache_op, cache_addr,
              ic_busy, dc_busy, ic_fill_done, dc_fill_done, dc_store_done};
   endfunction

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // expected outputs in cycle c (1..14) of a fill of block b owned by d (1 = D-cache)
   task automatic fill_expect(input int c, input logic [15:0] b, input logic d, input string t);
      logic iss, wc, tg, busy, done;
      iss  = (c <= 8);
      wc   = (c >= 5) && (c <= 12);
      tg   = (c == 13);
      busy = (c <= 13);
      done = (c == 14);
      check($sformatf("%s_c%0d", t, c), {22'd0, obs()},
            {22'd0, iss, 1'b0, iss ? b + 16'(2 * (c - 1)) : 16'h0,
             wc | tg, wc ? 2'b01 : tg ? 2'b10 : 2'b00,
             wc ? b + 16'(2 * (c - 5)) : tg ? b : 16'h0,
             busy & ~d, busy & d, done & ~d, done & d, 1'b0});
      if (wc) check($sformatf("%s_data_c%0d", t, c), {48'd0, cache_data}, {48'd0, 16'hA000 + 16'(c - 5)});
   endtask

   localparam logic [41:0] ZERO = 42'd0;

   initial begin
      step();
      step();
      check("reset_outputs", {22'd0, obs()}, {22'd0, ZERO});
      check("reset_cache_data", {48'd0, cache_data}, {48'd0, 16'hA000});
      rst_n = 1'b1;
      // I-cache fill; miss dropped mid-fill must not abort
      ic_miss = 1'b1; ic_addr = 16'h1236;
      for (int c = 1; c <= 14; c++) begin
         step();
         if (c == 3) ic_miss = 1'b0;
         fill_expect(c, 16'h1230, 1'b0, "t1");
      end
      step();
      check("t1_idle", {22'd0, obs()}, {22'd0, ZERO});
      // both miss with last_served = I: D first, then I
      ic_miss = 1'b1; ic_addr = 16'h9ABC; dc_miss = 1'b1; dc_addr = 16'h5678;
      for (int c = 1; c <= 14; c++) begin
         step();
         fill_expect(c, 16'h5670, 1'b1, "t2d");
         if (c == 14) dc_miss = 1'b0;
      end
      step();
      check("t2_gap", {22'd0, obs()}, {22'd0, ZERO});
      for (int c = 16; c <= 29; c++) begin
         step();
         if (c == 17) ic_miss = 1'b0;
         fill_expect(c - 15, 16'h9AB0, 1'b0, "t2i");
      end
      step();
      check("t2_idle", {22'd0, obs()}, {22'd0, ZERO});
      // write-through store
      dc_store = 1'b1; dc_addr = 16'h4002; dc_store_data = 16'hBEEF;
      step();
      check("t3_write", {22'd0, obs()}, {22'd0, 1'b1, 1'b1, 16'h4002, 1'b0, 2'b00, 16'h0, 5'b00001});
      check("t3_wdata", {48'd0, mem_wdata}, {48'd0, 16'hBEEF});
      dc_store = 1'b0;
      step();
      check("t3_idle", {22'd0, obs()}, {22'd0, ZERO});
      // store arriving during a fill waits for IDLE
      ic_miss = 1'b1; ic_addr = 16'h2000;
      for (int c = 1; c <= 14; c++) begin
         step();
         if (c == 1) begin
            ic_miss = 1'b0; dc_store = 1'b1; dc_addr = 16'h4010; dc_store_data = 16'h1234;
         end
         fill_expect(c, 16'h2000, 1'b0, "t4");
      end
      step();
      check("t4_wait", {22'd0, obs()}, {22'd0, ZERO});
      step();
      check("t4_write", {22'd0, obs()}, {22'd0, 1'b1, 1'b1, 16'h4010, 1'b0, 2'b00, 16'h0, 5'b00001});
      check("t4_wdata", {48'd0, mem_wdata}, {48'd0, 16'h1234});
      dc_store = 1'b0;
      step();
      check("t4_idle", {22'd0, obs()}, {22'd0, ZERO});
      // reset mid-fill, then restart from word 0
      ic_miss = 1'b1; ic_addr = 16'h3000;
      for (int c = 1; c <= 7; c++) begin
         step();
         fill_expect(c, 16'h3000, 1'b0, "t5a");
      end
      rst_n = 1'b0;
      #1;
      check("t5_rst_now", {22'd0, obs()}, {22'd0, ZERO});
      check("t5_rst_data", {48'd0, cache_data}, {48'd0, 16'hA000});
      step();
      check("t5_rst_hold1", {22'd0, obs()}, {22'd0, ZERO});
      step();
      check("t5_rst_hold2", {22'd0, obs()}, {22'd0, ZERO});
      rst_n = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         step();
         if (c == 1) ic_miss = 1'b0;
         fill_expect(c, 16'h3000, 1'b0, "t5b");
      end
      step();
      check("t5_idle", {22'd0, obs()}, {22'd0, ZERO});
      // spurious mem_data_valid while idle
      spur = 1'b1;
      #1;
      check("t6_spur", {22'd0, obs()}, {22'd0, ZERO});
      step();
      spur = 1'b0;
      check("t6_after", {22'd0, obs()}, {22'd0, ZERO});
      // top-of-memory block, no wrap
      ic_miss = 1'b1; ic_addr = 16'hFFFE;
      for (int c = 1; c <= 14; c++) begin
         step();
         if (c == 1) ic_miss = 1'b0;
         fill_expect(c, 16'hFFF0, 1'b0, "t7");
      end
      step();
      check("t7_idle", {22'd0, obs()}, {22'd0, ZERO});
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/cache_fill_arbiter.md
Name: cache_fill_arbiter

Overview:
- Sequences the shared 4-cycle main memory between the I-cache and D-cache toplevels.
- On a cache miss it reads the 8-word (16-byte) block from memory and writes each word into the cache with cacheop=01 (fill). It then commits the tag, LRU and valid bits with one cacheop=10 (set tag) cycle.
- It also issues D-cache write-through stores to memory.
- While it owns a cache port, the cpu toplevel muxes that cache's Address_Oper, Data_In, r_enabled and cacheop from this block.

Parameters:
- MEM_LATENCY, 4, cycles from a memory read issue to mem_data_valid.
- WORDS, 8, 16-bit words per cache block.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- ic_miss  in  1  I-cache miss_occurred.
- ic_addr  in  16  I-cache missing address.
- dc_miss  in  1  D-cache miss_occurred.
- dc_addr  in  16  D-cache missing or store address.
- dc_store  in  1  D-cache store request (write-through).
- dc_store_data  in  16  store data.
- mem_en  out  1  memory enable.
- mem_wr  out  1  memory write (1) / read (0).
- mem_addr  out  16  memory address.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data.
- mem_data_valid  in  1  mem_rdata is valid this cycle.
- ic_busy  out  1  controller owns the I-cache port.
- dc_busy  out  1  controller owns the D-cache port.
- cache_en  out  1  r_enabled to the owned cache.
- cache_op  out  2  cacheop to the owned cache.
- cache_addr  out  16  Address_Oper to the owned cache.
- cache_data  out  16  Data_In to the owned cache (combinational copy of mem_rdata).
- ic_fill_done  out  1  one-cycle pulse: I-cache fill committed.
- dc_fill_done  out  1  one-cycle pulse: D-cache fill committed.
- dc_store_done  out  1  one-cycle pulse: store written to memory.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; issue and receive counters clear; last_served = I-cache.
  - All outputs are 0, except cache_data, which follows mem_rdata.
  - Memory shares the reset, so no stale returns arrive afterwards.
- States: IDLE, FILL, TAG, DONE, WRITE.
- IDLE arbitration, evaluated each cycle and registered:
  - Priority 1: dc_miss and ic_miss both high -> serve the cache not in last_served.
  - Priority 2: exactly one miss high -> serve it.
  - Priority 3: dc_store & ~dc_miss -> WRITE.
  - On a miss grant: latch base = {addr[15:4], 4'b0000} and owner, set last_served = owner, go to FILL.
  - No outputs are driven in IDLE.
- FILL:
  - busy for the owner = 1.
  - Issue counter i (0..WORDS-1): each cycle with i < WORDS, drive mem_en=1, mem_wr=0, mem_addr = base + 2i, then i++. One issue per cycle, back-to-back.
  - Receive counter r: on each mem_data_valid, drive cache_en=1, cache_op=01, cache_addr = base + 2r, then r++.
  - Returns are in issue order.
  - When mem_data_valid arrives with r = WORDS-1, go to TAG.
  - mem_data_valid outside FILL is ignored.
- TAG (1 cycle): cache_en=1, cache_op=10, cache_addr=base; busy held; go to DONE.
  - The cache's miss path writes tag/valid/LRU into its evicted way.
- DONE (1 cycle): pulse the owner's fill_done; busy=0; cache_en=0; go to IDLE.
  - The cache now hits and the stalled requester proceeds.
  - A request arriving in DONE is granted from IDLE on the next cycle.
- WRITE (1 cycle):
  - mem_en=1, mem_wr=1, mem_addr = dc_addr, mem_wdata = dc_store_data; dc_store_done=1; go to IDLE.
  - dc_busy stays 0: the D-cache hit path handles the cache write itself.
- Latency, from the cycle a miss is seen in IDLE (cycle 0):
  - Issues in cycles 1..WORDS.
  - Last word written in cycle WORDS+MEM_LATENCY.
  - TAG in cycle WORDS+MEM_LATENCY+1.
  - fill_done in cycle WORDS+MEM_LATENCY+2, which is 14 at the defaults.
- Boundaries:
  - A requester deasserting its miss mid-fill does not abort the fill; base and owner are latched.
  - Requests that arrive during FILL, TAG or WRITE wait until IDLE.
  - ic_busy and dc_busy are never both 1.
  - The base address ignores addr[3:0]; address 0xFFFE fills block 0xFFF0..0xFFFE without wrap.
  - Reset in any state aborts immediately; no fill_done is produced.
- Width rules: counters are 4 bits (sized for WORDS up to 15); the fill address uses 16-bit addition.

Test Plan:
1. I-cache fill: ic_miss=1, ic_addr=0x1236.
   - Reads issued in cycles 1..8 to 0x1230, 0x1232, ..., 0x123E.
   - Memory returns 0xA000+k for word k; cache_op=01 writes cache_addr 0x1230+2k with data 0xA000+k in cycles 5..12.
   - cache_op=10 in cycle 13; ic_fill_done in cycle 14.
2. Simultaneous misses: ic_miss and dc_miss both high, last_served=I.
   - D-cache served first (dc_busy=1, dc_fill_done at cycle 14).
   - I-cache fill granted at cycle 15; ic_fill_done at cycle 29.
3. Store: dc_store=1, dc_miss=0, dc_addr=0x4002, data 0xBEEF.
   - Next cycle: mem_en=1, mem_wr=1, addr 0x4002, wdata 0xBEEF, dc_store_done=1.
   - Returns to IDLE the following cycle.
4. Store waits behind a fill: dc_store during an I-cache fill.
   - No memory write before ic_fill_done.
   - Write issued exactly 2 cycles after the ic_fill_done pulse.
5. Reset mid-fill: rst=0 at cycle 7 of an I-cache fill.
   - All outputs 0 immediately; no ic_fill_done.
   - After reset release, ic_miss=1 restarts the fill from word 0.
6. Spurious mem_data_valid while in IDLE: no cache_en, state stays IDLE.
